fractal_sync_tx_arb: RTL
========================

// Module: fractal_sync_tx_arb
// PURPOSE
//  Round-robin drain controller for the response FIFOs of N fractal_sync_tx datapaths (en or ws side).
//  Pops at most one response per cycle from the non-empty, enabled FIFO heads into a single output register.
//  Presents the output register to one downstream sync channel with valid/ready.
//  Collects per-port FIFO overflow errors into sticky flags.
// PARAMETERS
//  fsync_rsp_t  logic  type of a synchronization response (FIFO element)
//  N_PORTS      4      number of tx FIFOs arbitrated; >= 1
//  IDX_W        localparam = (N_PORTS > 1) ? $clog2(N_PORTS) : 1; width of port index
// PORTS
//  clk_i           in   1              clock
//  rst_ni          in   1              reset, synchronous, active-low
//  empty_i         in   N_PORTS        FIFO k empty
//  rsp_i           in   N_PORTS x rsp  FIFO k head element (fall-through FIFO, valid when !empty_i[k])
//  pop_o           out  N_PORTS        pop FIFO k this cycle (one-hot or zero)
//  en_mask_i       in   N_PORTS        port k eligible for grant
//  overflow_i      in   N_PORTS        FIFO k overflow pulse from datapath
//  clr_err_i       in   1              clear all sticky error flags
//  rsp_o           out  rsp            output response
//  valid_o         out  1              rsp_o valid
//  ready_i         in   1              downstream accepts rsp_o
//  grant_idx_o     out  IDX_W          source port of current rsp_o
//  err_o           out  N_PORTS        sticky overflow flag per port
//  busy_o          out  1              valid_o | any eligible non-empty port
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): valid_o=0, rsp_o='0, grant_idx_o=0, err_o='0, RR pointer=0; pop_o=0 while rst_ni=0.
//  Request vector: req[k] = ~empty_i[k] & en_mask_i[k].
//  Output register states: EMPTY (valid_o=0) / FULL (valid_o=1).
//  can_load = ~valid_o | ready_i (load permitted in FULL when the current entry is accepted the same cycle).
//  Grant: if can_load & |req, select first k with req[k] scanning ptr, ptr+1, ... modulo N_PORTS; pop_o[k]=1 combinationally, same cycle.
//  On grant: next cycle rsp_o=rsp_i[k], grant_idx_o=k, valid_o=1, ptr <= (k+1) mod N_PORTS (wrap at N_PORTS-1 -> 0).
//  No grant: ptr unchanged; if valid_o & ready_i, valid_o <= 0; rsp_o and grant_idx_o hold their last values.
//  Latency: FIFO head to valid_o = 1 cycle; back-to-back throughput 1 rsp/cycle while ready_i=1.
//  Handshake: rsp_o/grant_idx_o stable while valid_o & ~ready_i; valid_o never drops without ready_i.
//  Fairness: a port with req held high is granted within N_PORTS grants.
//  Port k with en_mask_i[k]=0 is never popped; masking does not affect the entry already in rsp_o.
//  pop_o[k] is never asserted while empty_i[k]=1 (no underflow generated).
//  Errors: err_o[k] <= 1 on overflow_i[k]; clr_err_i clears all flags; if clr_err_i and overflow_i[k] are asserted in the same cycle, set wins for that k.
//  busy_o combinational; N_PORTS=1: ptr constant 0, degenerates to pass-through register.
//  Reset mid-transfer: the entry in rsp_o is discarded; the FIFOs are not popped.
// STRUCTURE
//  No new package types; fsync_rsp_t comes from fractal_sync_pkg users.
//  Sub-module fractal_sync_rr_arb #(N_PORTS): req, ptr -> one-hot gnt + idx (combinational priority rotate).
//  Top level holds ptr, output register, error flags.
// TESTING
//  1. Reset, all empty_i=1 -> valid_o=0, pop_o=0, busy_o=0, err_o=0.
//  2. N=4, ports 0,2,3 non-empty, ready_i=1 continuously -> pops 0,2,3,0... one per cycle; grant_idx_o=0,2,3 on consecutive cycles.
//  3. ready_i=0 for 5 cycles while valid_o=1 -> pop_o=0, rsp_o stable; ready_i=1 -> new grant in the same cycle.
//  4. en_mask_i=4'b1011 with all ports non-empty -> port 2 never popped; unmasking -> port 2 granted within 4 grants.
//  5. overflow_i[1] pulse -> err_o=4'b0010; clr_err_i together with overflow_i[3] -> err_o=4'b1000.
//  6. Assert rst_ni=0 while valid_o=1 and ready_i=0 -> next cycle valid_o=0, ptr=0, no pop issued.

Source files
------------

// File: rtl/fractal_sync_tx_arb_pkg.sv
// Shared definitions for the fractal_sync tx response drain arbiter:
// output-register state encoding and the port-index width helper.
package fractal_sync_tx_arb_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // A single port still needs a 1-bit index so the port widths stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fractal_sync_tx_arb_if.sv
// FIFO-side and downstream-side signals of the tx drain arbiter.
// slave = arbiter view, master = the environment driving it.
interface fractal_sync_tx_arb_if #(
  parameter int  N_PORTS = 4,
  parameter type rsp_t   = logic
);
  localparam int IDX_W = fractal_sync_tx_arb_pkg::idx_width(N_PORTS);

  logic [N_PORTS-1:0] empty_i;
  rsp_t               rsp_i [N_PORTS];
  logic [N_PORTS-1:0] pop_o;
  logic [N_PORTS-1:0] en_mask_i;
  logic [N_PORTS-1:0] overflow_i;
  logic               clr_err_i;
  rsp_t               rsp_o;
  logic               valid_o;
  logic               ready_i;
  logic [IDX_W-1:0]   grant_idx_o;
  logic [N_PORTS-1:0] err_o;
  logic               busy_o;

  modport slave (
    input  empty_i, rsp_i, en_mask_i, overflow_i, clr_err_i, ready_i,
    output pop_o, rsp_o, valid_o, grant_idx_o, err_o, busy_o
  );

  modport master (
    output empty_i, rsp_i, en_mask_i, overflow_i, clr_err_i, ready_i,
    input  pop_o, rsp_o, valid_o, grant_idx_o, err_o, busy_o
  );

endinterface

// File: rtl/fractal_sync_tx_arb_rr.sv
// Combinational round-robin pick: first requester at or after ptr_i,
// wrapping modulo N_PORTS; returns one-hot grant and its index.
module fractal_sync_rr_arb
  import fractal_sync_tx_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = idx_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] rot_idx [N_PORTS];

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_rot
    assign rot_idx[gi] = IDX_W'((int'(ptr_i) + gi) % N_PORTS);
  end

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    gnt_o   = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req_i[rot_idx[i]]) begin
        idx_o   = rot_idx[i];
        valid_o = 1'b1;
      end
    end
    if (valid_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/fractal_sync_tx_arb.sv
// Round-robin drain of N tx response FIFOs into one valid/ready output
// register, plus sticky per-port overflow flags.
module fractal_sync_tx_arb
  import fractal_sync_tx_arb_pkg::*;
#(
  parameter type fsync_rsp_t = logic,
  parameter int  N_PORTS     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  fractal_sync_tx_arb_if.slave  bus
);
  localparam int IDX_W = idx_width(N_PORTS);

  out_state_e         state_q, state_d;
  fsync_rsp_t         rsp_q, rsp_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_PORTS-1:0] err_q, err_d;
  logic [N_PORTS-1:0] req, arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid, can_load, grant;

  assign req      = ~bus.empty_i & bus.en_mask_i;
  // A full register may reload in the cycle its entry is being accepted.
  assign can_load = (state_q == OUT_EMPTY) | bus.ready_i;
  assign grant    = rst_ni & can_load & arb_valid;

  fractal_sync_rr_arb #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    // Set beats clear for a port that overflows in the clearing cycle.
    err_d   = (bus.clr_err_i ? '0 : err_q) | bus.overflow_i;
    if (grant) begin
      state_d = OUT_FULL;
      rsp_d   = bus.rsp_i[arb_idx];
      idx_d   = arb_idx;
      ptr_d   = (int'(arb_idx) == N_PORTS - 1) ? '0 : arb_idx + IDX_W'(1);
    end else if (state_q == OUT_FULL && bus.ready_i) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= OUT_EMPTY;
      rsp_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign bus.pop_o       = grant ? arb_gnt : '0;
  assign bus.valid_o     = (state_q == OUT_FULL);
  assign bus.rsp_o       = rsp_q;
  assign bus.grant_idx_o = idx_q;
  assign bus.err_o       = err_q;
  assign bus.busy_o      = (state_q == OUT_FULL) | (|req);

endmodule
